// File: rtl/risc_trace_buffer.sv
// risc_trace_buffer: snoops the retired PC/IR stream into a circular buffer,
// freezes a programmable number of samples after a selected opcode retires,
// and exposes the frozen history through a registered read port.
module risc_trace_buffer #(
   parameter int DATA_WIDTH   = 32,
   parameter int OPCODE_WIDTH = 7,
   parameter int DEPTH        = 16,
   parameter int PTR_WIDTH    = 4,
   parameter int POST_COUNT   = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    arm,
   input  logic                    trig_en,
   input  logic [OPCODE_WIDTH-1:0] trig_opcode,
   input  logic                    retire_valid,
   input  logic [DATA_WIDTH-1:0]   retire_pc,
   input  logic [DATA_WIDTH-1:0]   retire_ir,
   input  logic [PTR_WIDTH-1:0]    rd_addr,
   output logic [DATA_WIDTH-1:0]   rd_pc,
   output logic [DATA_WIDTH-1:0]   rd_ir,
   output logic [1:0]              state,
   output logic [PTR_WIDTH:0]      count,
   output logic [PTR_WIDTH-1:0]    trig_index,
   output logic                    wrapped,
   output logic                    done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PRE  = 2'd1,
      POST = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam logic [PTR_WIDTH:0]   FULL      = (PTR_WIDTH+1)'(DEPTH);
   localparam logic [PTR_WIDTH-1:0] POST_INIT = PTR_WIDTH'(POST_COUNT);

   state_t                  state_q, state_d;
   logic [PTR_WIDTH-1:0]    wr_ptr;
   logic [PTR_WIDTH:0]      count_q;
   logic [PTR_WIDTH-1:0]    post_cnt;
   logic [PTR_WIDTH-1:0]    trig_idx_q;
   logic                    wrapped_q;
   logic                    capture;
   logic                    trig_hit;
   logic                    full;
   logic [PTR_WIDTH:0]      count_after;
   logic [PTR_WIDTH-1:0]    rd_phys;
   logic                    rd_hit;

   logic [DATA_WIDTH-1:0]   mem_pc [DEPTH];
   logic [DATA_WIDTH-1:0]   mem_ir [DEPTH];

   assign full        = (count_q == FULL);
   assign count_after = full ? count_q : count_q + (PTR_WIDTH+1)'(1);
   // count==DEPTH truncates to 0 here, which correctly points at wr_ptr (the oldest entry).
   assign rd_phys     = wr_ptr - count_q[PTR_WIDTH-1:0] + rd_addr;
   assign rd_hit      = ({1'b0, rd_addr} < count_q);

   // Next-state and capture/trigger decode; arm overrides everything.
   always_comb begin
      // NOTE: every combinational output gets a default first so no latch is inferred.
      state_d  = state_q;
      capture  = 1'b0;
      trig_hit = 1'b0;
      if (state_q == PRE || state_q == POST) capture = retire_valid && !arm;
      trig_hit = (state_q == PRE) && capture && trig_en &&
                 (retire_ir[31 -: OPCODE_WIDTH] == trig_opcode);
      if (arm) begin
         state_d = PRE;
      end else begin
         case (state_q)
            PRE:     if (trig_hit) state_d = (POST_COUNT == 0) ? DONE : POST;
            POST:    if (capture && post_cnt == PTR_WIDTH'(1)) state_d = DONE;
            default: state_d = state_q;
         endcase
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Write pointer, fill count, wrap flag, post counter and trigger index.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         count_q    <= '0;
         wrapped_q  <= 1'b0;
         post_cnt   <= '0;
         trig_idx_q <= '0;
      end else if (arm) begin
         wr_ptr     <= '0;
         count_q    <= '0;
         wrapped_q  <= 1'b0;
         post_cnt   <= '0;
         trig_idx_q <= '0;
      end else if (capture) begin
         wr_ptr  <= wr_ptr + PTR_WIDTH'(1);
         count_q <= count_after;
         if (full) wrapped_q <= 1'b1;
         if (trig_hit) begin
            trig_idx_q <= count_after[PTR_WIDTH-1:0] - PTR_WIDTH'(1);
            post_cnt   <= POST_INIT;
         end else if (state_q == POST) begin
            post_cnt <= post_cnt - PTR_WIDTH'(1);
            // Oldest entry is being overwritten, so the trigger slides one slot toward index 0.
            if (full) trig_idx_q <= trig_idx_q - PTR_WIDTH'(1);
         end
      end
   end

   // Sample storage.
   always_ff @(posedge clk) begin
      // NOTE: storage has no reset; entries beyond count are masked on readout instead.
      if (capture) begin
         mem_pc[wr_ptr] <= retire_pc;
         mem_ir[wr_ptr] <= retire_ir;
      end
   end

   // Registered readout in logical (oldest-first) order; empty slots read as zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_pc <= '0;
         rd_ir <= '0;
      end else if (rd_hit) begin
         rd_pc <= mem_pc[rd_phys];
         rd_ir <= mem_ir[rd_phys];
      end else begin
         rd_pc <= '0;
         rd_ir <= '0;
      end
   end

   assign state      = state_q;
   assign count      = count_q;
   assign trig_index = trig_idx_q;
   assign wrapped    = wrapped_q;
   assign done       = (state_q == DONE);

endmodule
